serial_tx_scheduler: RTL
========================

Name: serial_tx_scheduler

Overview:
- Shares one serial transmit line among NREQ parallel requesters.
- Arbitrates round-robin and latches the winner's length and payload.
- Serialises the winner as a frame: one start bit of 0, then a 4-bit length MSB-first, then the payload LSB-first.
- Each bit is advanced by the step-enable pulse from the existing one-pulser. It drives the same frame format the serial transmitter/detector consumes.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LW, 4, length field width; the payload width is PW = 2**LW-1 = 15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- step_en  in  1  single-cycle bit-advance enable (from the one-pulser).
- req  in  NREQ  request per requester; must be held until the matching ack.
- len  in  NREQ*LW  per-requester payload bit count (0..15), slice i at [i*LW +: LW].
- data  in  NREQ*PW  per-requester payload, slice i at [i*PW +: PW].
- ser_out  out  1  serial line; idle level is 1.
- ser_busy  out  1  high from grant until return to IDLE.
- grant  out  NREQ  one-hot; the requester currently owning the line.
- ack  out  NREQ  one-cycle pulse when that requester's frame has been fully sent.
- bits_left  out  LW  payload bits still to send; feeds the SSD display.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, ser_out=1, ser_busy=0, grant=0, ack=0, bits_left=0.
  - RR pointer=0, so requester 0 has highest priority.
  - Reset applied mid-frame aborts the frame: the line is high the next cycle and no ack is issued.
- All outputs are registered.
- States: IDLE, START, LEN, DATA, GAP.
- IDLE:
  - Arbitration runs every cycle, independent of step_en.
  - Search order is ptr, ptr+1, ..., wrapping modulo NREQ.
  - If any req is set: next cycle grant=onehot(w), ser_busy=1, ser_out=0 (start bit), state=START.
  - On the same edge: len_q=len[w], data_q=data[w], ptr=w+1 mod NREQ.
- START: on step_en -> LEN, ser_out=len_q[LW-1], bit index k=LW-1.
- LEN:
  - Each step_en advances k down to 0, driving ser_out=len_q[k].
  - On step_en with k==0:
    - if len_q!=0: -> DATA, ser_out=data_q[0], bits_left=len_q-1.
    - if len_q==0: -> GAP, ser_out=1, ack[w] pulses.
- DATA:
  - Each step_en shifts to the next payload bit (LSB-first) and decrements bits_left.
  - On step_en with bits_left==0: -> GAP, ser_out=1, ack[w] pulses for exactly one cycle.
- GAP:
  - Guarantees at least one idle-high bit between frames.
  - On step_en -> IDLE, grant=0, ser_busy=0.
  - A pending req may be granted the cycle after entering IDLE.
- Without step_en, every state holds and ser_out is stable.
- Frame length is 1+LW+len_q bit periods, plus one GAP bit.
- Payload bits above len_q-1 are ignored.
- req dropped mid-frame: the frame still completes and ack is still issued. The requester may drop req only after ack.
- A requester that re-requests immediately after its ack is served after all other pending requesters (fairness).
- step_en asserted in the same cycle as the grant decision is ignored for bit advance; START always lasts at least one full step.
- len and data changing after grant have no effect; they were latched at grant.

Decomposition:
- Package serial_tx_pkg:
  - state enum (IDLE, START, LEN, DATA, GAP).
  - constants IDLE_LEVEL=1'b1, START_BIT=1'b0, default LW=4.
- One sub-module, rr_arbiter (parameter NREQ):
  - combinational round-robin pick from req and ptr.
  - outputs winner index and valid flag.
  - ptr register held in the scheduler.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then req=0 with step_en pulsing -> ser_out stays 1, grant=0, ser_busy=0.
- Single frame: req[1]=1, len[1]=3, data[1]=15'b101, step_en every 4th cycle -> ser_out bits per step: 0, 0,0,1,1, 1,0,1, then 1 (gap); ack[1] pulses once; bits_left 2,1,0.
- Zero-length frame: req[2], len=0 -> bits 0,0000 then gap 1; ack[2] after 5 steps; DATA never entered.
- Round-robin: req=4'b1111 held, each requester dropping req after its ack -> grant order 0,1,2,3; re-raising req[0] after its ack while req[3] is pending -> 3 is served before 0.
- Mid-frame reset: assert rst=0 during DATA of len=15 -> next cycle ser_out=1, grant=0, no ack; after release, arbitration restarts with requester 0 priority.
- Step gating: hold step_en=0 for 50 cycles in LEN -> ser_out unchanged; the same req/len/data changed mid-frame -> transmitted bits match the values latched at grant.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmit scheduler.
//   state_e    : frame sequencer states
//   IDLE_LEVEL : level of the serial line between frames
//   START_BIT  : level of the frame start bit
//   DEFAULT_LW : default length field width (payload width is 2**LW-1)
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LEN,
    DATA,
    GAP
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam int   DEFAULT_LW = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req       : request vector
//   ptr       : highest-priority index for this decision
//   win_idx   : first requesting index found from ptr upward, wrapping
//   win_valid : at least one request is set
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [PTRW-1:0] win_idx,
  output logic            win_valid
);

  logic [PTRW-1:0] cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PTRW'((32'(ptr) + i) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one serial line among NREQ requesters. A round-robin winner has its
// length and payload latched at grant, then is sent as: start bit (0),
// LW-bit length MSB-first, payload LSB-first, and one idle-high gap bit.
// Every bit advance is gated by step_en.
//   clk, rst  : clock, synchronous active-low reset
//   step_en   : single-cycle bit-advance enable
//   req       : per-requester request, held until ack
//   len, data : per-requester length (slice i*LW) and payload (slice i*PW)
//   ser_out   : serial line, idles high
//   ser_busy  : high from grant until return to IDLE
//   grant     : one-hot owner of the line
//   ack       : one-cycle pulse when the owner's frame is complete
//   bits_left : payload bits still to send
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LW   = DEFAULT_LW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LW-1:0]     len,
  input  logic [NREQ*(2**LW-1)-1:0] data,
  output logic                   ser_out,
  output logic                   ser_busy,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ack,
  output logic [LW-1:0]          bits_left
);

  localparam int PW   = 2**LW - 1;
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            ser_q, ser_d;
  logic            busy_q, busy_d;
  logic [LW-1:0]   bits_left_q, bits_left_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   len_sh_q, len_sh_d;
  logic [LW-1:0]   k_q, k_d;
  logic [PW-1:0]   data_q, data_d;

  logic [PTRW-1:0] win_idx;
  logic            win_valid;

  rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    ser_d       = ser_q;
    busy_d      = busy_q;
    bits_left_d = bits_left_q;
    len_d       = len_q;
    len_sh_d    = len_sh_q;
    k_d         = k_q;
    data_d      = data_q;

    unique case (state_q)
      IDLE: begin
        // Arbitration ignores step_en so START always lasts a full step.
        if (win_valid) begin
          state_d = START;
          grant_d = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          ser_d   = START_BIT;
          len_d   = len[32'(win_idx)*LW +: LW];
          data_d  = data[32'(win_idx)*PW +: PW];
          ptr_d   = (win_idx == PTRW'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end
      end
      START: begin
        if (step_en) begin
          state_d  = LEN;
          ser_d    = len_q[LW-1];
          len_sh_d = len_q << 1;
          k_d      = LW'(LW-1);
        end
      end
      LEN: begin
        // Length bits come from a shift copy so len_q stays intact for DATA.
        if (step_en) begin
          if (k_q == '0) begin
            if (len_q != '0) begin
              state_d     = DATA;
              ser_d       = data_q[0];
              data_d      = data_q >> 1;
              bits_left_d = len_q - 1'b1;
            end else begin
              state_d = GAP;
              ser_d   = IDLE_LEVEL;
              ack_d   = grant_q;
            end
          end else begin
            k_d      = k_q - 1'b1;
            ser_d    = len_sh_q[LW-1];
            len_sh_d = len_sh_q << 1;
          end
        end
      end
      DATA: begin
        if (step_en) begin
          if (bits_left_q == '0) begin
            state_d = GAP;
            ser_d   = IDLE_LEVEL;
            ack_d   = grant_q;
          end else begin
            ser_d       = data_q[0];
            data_d      = data_q >> 1;
            bits_left_d = bits_left_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (step_en) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      ser_q       <= IDLE_LEVEL;
      busy_q      <= 1'b0;
      bits_left_q <= '0;
      len_q       <= '0;
      len_sh_q    <= '0;
      k_q         <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      ser_q       <= ser_d;
      busy_q      <= busy_d;
      bits_left_q <= bits_left_d;
      len_q       <= len_d;
      len_sh_q    <= len_sh_d;
      k_q         <= k_d;
      data_q      <= data_d;
    end
  end

  assign ser_out   = ser_q;
  assign ser_busy  = busy_q;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign bits_left = bits_left_q;

endmodule
